acc_x_wb_serializer: RTL and testbench
======================================

Name: acc_x_wb_serializer

Overview:
- Sits between the accelerator adapter's X-response output and the core's single-port integer register file writeback.
- Accepts X responses, which may carry dual writeback (rd and rd+1), and emits them as one or two single-register write beats over a valid/ready writeback port.
- Holds one response at a time in a registered stage, so the adapter's response path is decoupled from core writeback stalls.

Parameters:
- DataWidth, 32, width of one register write.
- DualWriteback, 1, enables the dual-writeback path; when 0, dualwb_i is ignored.
- RegAddrWidth, 5, width of the register address.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-high.
- x_rsp_valid_i  in  1  X response valid.
- x_rsp_ready_o  out  1  X response accepted.
- x_rsp_rd_i  in  RegAddrWidth  destination register.
- x_rsp_data_i  in  2*DataWidth  [DataWidth-1:0] is the rd value; upper half is the rd+1 value.
- x_rsp_dualwb_i  in  1  response writes rd and rd+1.
- x_rsp_error_i  in  1  accelerator error flag.
- wb_valid_o  out  1  writeback beat valid.
- wb_ready_i  in  1  register file accepts beat.
- wb_addr_o  out  RegAddrWidth  write address.
- wb_data_o  out  DataWidth  write data.
- wb_error_o  out  1  beat error flag.
- busy_o  out  1  a response is held (state != EMPTY).

Behaviour:
- State machine: EMPTY, FIRST, SECOND; state is registered.
- Reset (rst_n=1, asynchronous): state=EMPTY; wb_valid_o=0, wb_addr_o=0, wb_data_o=0, wb_error_o=0, busy_o=0, x_rsp_ready_o=1. A response held when reset asserts is discarded; no beat is emitted for it.
- Holding registers: rd, both data words, dual, error. Captured on an input handshake (x_rsp_valid_i & x_rsp_ready_o).
- dual is captured as x_rsp_dualwb_i & DualWriteback.
- last_beat = (state==FIRST & !dual) | (state==SECOND).
- x_rsp_ready_o = (state==EMPTY) | (wb_valid_o & wb_ready_i & last_beat). Back-to-back responses therefore see no bubble on the input side.
- Transitions:
  - EMPTY: on input handshake -> FIRST.
  - FIRST: on output handshake -> SECOND if dual; else FIRST if a new input is accepted in the same cycle; else EMPTY.
  - SECOND: on output handshake -> FIRST if a new input is accepted in the same cycle; else EMPTY.
- Outputs:
  - wb_valid_o = (state != EMPTY).
  - FIRST: wb_addr_o=rd, wb_data_o=low word.
  - SECOND: wb_addr_o=(rd+1) mod 2^RegAddrWidth, wb_data_o=high word.
- Latency: the first beat appears the cycle after input acceptance. A dual response occupies at least 2 output cycles.
- Output stability: while wb_valid_o=1 and wb_ready_i=0, addr, data and error hold stable.
- Error flag: wb_error_o = held error on every beat.
- Wrap-around: a dual response with rd = 2^RegAddrWidth-1 writes its second beat to address 0 and forces wb_error_o=1 on that second beat.
- x0 handling: beats to address 0 are still emitted; the register file ignores them.
- Input with x_rsp_valid_i=0: no state change apart from output draining.

Optional Feature:
- Macro: ACC_WB_SERIALIZER_PERF_CNT_EN.
- When defined, adds outputs perf_rsp_cnt_o (32 bits) and perf_dual_cnt_o (32 bits). These count accepted responses and accepted dual responses respectively.
- Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then idle -> wb_valid_o=0, x_rsp_ready_o=1, busy_o=0.
- Single response: rd=5, data low=32'hDEAD_BEEF, dualwb=0, wb_ready_i=1 -> one beat the next cycle with addr=5, data=32'hDEAD_BEEF, error=0; then state EMPTY.
- Dual response: rd=10, low=32'h1111_1111, high=32'h2222_2222 -> beat addr 10 / 32'h1111_1111, then addr 11 / 32'h2222_2222; x_rsp_ready_o=0 during the first beat.
- Dual with rd=31 -> second beat addr 0 with wb_error_o=1. With DualWriteback=0 the same stimulus gives a single beat, addr 31.
- wb_ready_i held low for 4 cycles during the FIRST beat -> outputs stable, x_rsp_ready_o=0. Releasing wb_ready_i with a new single response pending -> new response accepted in the same cycle, next beat emitted with no bubble.
- Assert rst_n mid-dual in SECOND -> wb_valid_o drops immediately, no rd+1 beat after reset release. With the macro defined, after 3 accepted responses (1 dual) counters read 3 and 1.

Source files
------------

// File: rtl/acc_x_wb_serializer.sv
// Purpose : Serializes X-interface responses, which may carry dual writeback
//           (rd and rd+1), into single-register writeback beats for the core's
//           single-port integer register file. One response is held at a time
//           in a registered stage, so core writeback stalls do not reach back
//           into the adapter's response path.
// Ports   : clk_i, rst_n          clock (rising edge), async active-high reset
//           x_rsp_*               X response input (valid/ready handshake)
//           wb_*                  writeback beat output (valid/ready handshake)
//           busy_o                a response is currently held
//           perf_*_cnt_o          saturating response counters (optional)
// Options : define ACC_WB_SERIALIZER_PERF_CNT_EN to add perf_rsp_cnt_o and
//           perf_dual_cnt_o.
module acc_x_wb_serializer #(
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned DualWriteback = 1,
   parameter int unsigned RegAddrWidth  = 5
) (
   input  logic                      clk_i,
   input  logic                      rst_n,
   input  logic                      x_rsp_valid_i,
   output logic                      x_rsp_ready_o,
   input  logic [RegAddrWidth-1:0]   x_rsp_rd_i,
   input  logic [2*DataWidth-1:0]    x_rsp_data_i,
   input  logic                      x_rsp_dualwb_i,
   input  logic                      x_rsp_error_i,
   output logic                      wb_valid_o,
   input  logic                      wb_ready_i,
   output logic [RegAddrWidth-1:0]   wb_addr_o,
   output logic [DataWidth-1:0]      wb_data_o,
   output logic                      wb_error_o,
   output logic                      busy_o
`ifdef ACC_WB_SERIALIZER_PERF_CNT_EN
   ,
   output logic [31:0]               perf_rsp_cnt_o,
   output logic [31:0]               perf_dual_cnt_o
`endif
);

   localparam int unsigned CntWidth = 32;
   localparam logic        DualEn   = (DualWriteback != 0);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      FIRST  = 2'd1,
      SECOND = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [RegAddrWidth-1:0] rd_q, rd_d;
   logic [DataWidth-1:0]    lo_q, lo_d;
   logic [DataWidth-1:0]    hi_q, hi_d;
   logic                    dual_q, dual_d;
   logic                    err_q, err_d;
   logic [RegAddrWidth-1:0] addr_d;
   logic [DataWidth-1:0]    data_d;
   logic                    werr_d;
   logic                    in_hs;
   logic                    out_hs;
   logic                    last_beat;

   // Handshake and decode of the held response
   assign wb_valid_o    = (state_q != EMPTY);
   assign busy_o        = (state_q != EMPTY);
   assign last_beat     = ((state_q == FIRST) && !dual_q) || (state_q == SECOND);
   assign out_hs        = wb_valid_o && wb_ready_i;
   // Accepting on the last beat's handshake removes the input-side bubble
   assign x_rsp_ready_o = (state_q == EMPTY) || (out_hs && last_beat);
   assign in_hs         = x_rsp_valid_i && x_rsp_ready_o;

   // Next state, holding-register capture and next output beat
   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      dual_d  = dual_q;
      err_d   = err_q;
      addr_d  = '0;
      data_d  = '0;
      werr_d  = 1'b0;

      if (in_hs) begin
         rd_d   = x_rsp_rd_i;
         lo_d   = x_rsp_data_i[DataWidth-1:0];
         hi_d   = x_rsp_data_i[2*DataWidth-1:DataWidth];
         dual_d = x_rsp_dualwb_i && DualEn;
         err_d  = x_rsp_error_i;
      end

      case (state_q)
         EMPTY: begin
            if (in_hs) state_d = FIRST;
         end
         FIRST: begin
            if (out_hs) begin
               if (dual_q)     state_d = SECOND;
               else if (in_hs) state_d = FIRST;
               else            state_d = EMPTY;
            end
         end
         SECOND: begin
            if (out_hs) state_d = in_hs ? FIRST : EMPTY;
         end
         default: state_d = EMPTY;
      endcase

      // Outputs are registered, so they are derived from the next state
      case (state_d)
         FIRST: begin
            addr_d = rd_d;
            data_d = lo_d;
            werr_d = err_d;
         end
         SECOND: begin
            // rd+1 wraps to x0; a wrapped second beat is flagged as an error
            addr_d = rd_d + RegAddrWidth'(1);
            data_d = hi_d;
            werr_d = err_d || (rd_d == {RegAddrWidth{1'b1}});
         end
         default: begin
            addr_d = '0;
            data_d = '0;
            werr_d = 1'b0;
         end
      endcase
   end

   // State, holding and output registers
   always_ff @(posedge clk_i or posedge rst_n) begin
      if (rst_n) begin
         state_q    <= EMPTY;
         rd_q       <= '0;
         lo_q       <= '0;
         hi_q       <= '0;
         dual_q     <= 1'b0;
         err_q      <= 1'b0;
         wb_addr_o  <= '0;
         wb_data_o  <= '0;
         wb_error_o <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_q       <= rd_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
         dual_q     <= dual_d;
         err_q      <= err_d;
         wb_addr_o  <= addr_d;
         wb_data_o  <= data_d;
         wb_error_o <= werr_d;
      end
   end

`ifdef ACC_WB_SERIALIZER_PERF_CNT_EN
   logic dual_acc;
   assign dual_acc = in_hs && x_rsp_dualwb_i && DualEn;

   // Saturating counters of accepted responses and accepted dual responses
   always_ff @(posedge clk_i or posedge rst_n) begin
      if (rst_n) begin
         perf_rsp_cnt_o  <= '0;
         perf_dual_cnt_o <= '0;
      end else begin
         if (in_hs && (perf_rsp_cnt_o != {CntWidth{1'b1}}))
            perf_rsp_cnt_o <= perf_rsp_cnt_o + CntWidth'(1);
         if (dual_acc && (perf_dual_cnt_o != {CntWidth{1'b1}}))
            perf_dual_cnt_o <= perf_dual_cnt_o + CntWidth'(1);
      end
   end
`endif

endmodule

// File: tb/tb_acc_x_wb_serializer.sv
// Purpose : Self-checking bench for acc_x_wb_serializer. Directed scenarios plus
//           a randomized run checked against a beat-queue reference model.
// Ports   : none (top-level bench). Instantiates one DUT with dual writeback
//           enabled and one with it disabled.
// Options : ACC_WB_SERIALIZER_PERF_CNT_EN also enables the counter scenario.
module tb_acc_x_wb_serializer;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          err;
   } beat_t;

   logic            clk_i = 1'b0;
   logic            rst_n;
   logic            x_rsp_valid;
   logic            nd_valid;
   logic [AW-1:0]   x_rsp_rd;
   logic [2*DW-1:0] x_rsp_data;
   logic            x_rsp_dualwb;
   logic            x_rsp_error;
   logic            wb_ready;

   logic            x_rsp_ready, wb_valid, wb_error, busy;
   logic [AW-1:0]   wb_addr;
   logic [DW-1:0]   wb_data;
   logic            nd_ready, nd_wb_valid, nd_wb_error, nd_busy;
   logic [AW-1:0]   nd_wb_addr;
   logic [DW-1:0]   nd_wb_data;
`ifdef ACC_WB_SERIALIZER_PERF_CNT_EN
   logic [31:0]     perf_rsp, perf_dual, nd_perf_rsp, nd_perf_dual;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   acc_x_wb_serializer #(.DataWidth(DW), .DualWriteback(1), .RegAddrWidth(AW)) dut (
      .clk_i          (clk_i),
      .rst_n          (rst_n),
      .x_rsp_valid_i  (x_rsp_valid),
      .x_rsp_ready_o  (x_rsp_ready),
      .x_rsp_rd_i     (x_rsp_rd),
      .x_rsp_data_i   (x_rsp_data),
      .x_rsp_dualwb_i (x_rsp_dualwb),
      .x_rsp_error_i  (x_rsp_error),
      .wb_valid_o     (wb_valid),
      .wb_ready_i     (wb_ready),
      .wb_addr_o      (wb_addr),
      .wb_data_o      (wb_data),
      .wb_error_o     (wb_error),
      .busy_o         (busy)
`ifdef ACC_WB_SERIALIZER_PERF_CNT_EN
      ,
      .perf_rsp_cnt_o (perf_rsp),
      .perf_dual_cnt_o(perf_dual)
`endif
   );

   acc_x_wb_serializer #(.DataWidth(DW), .DualWriteback(0), .RegAddrWidth(AW)) dut_nd (
      .clk_i          (clk_i),
      .rst_n          (rst_n),
      .x_rsp_valid_i  (nd_valid),
      .x_rsp_ready_o  (nd_ready),
      .x_rsp_rd_i     (x_rsp_rd),
      .x_rsp_data_i   (x_rsp_data),
      .x_rsp_dualwb_i (x_rsp_dualwb),
      .x_rsp_error_i  (x_rsp_error),
      .wb_valid_o     (nd_wb_valid),
      .wb_ready_i     (wb_ready),
      .wb_addr_o      (nd_wb_addr),
      .wb_data_o      (nd_wb_data),
      .wb_error_o     (nd_wb_error),
      .busy_o         (nd_busy)
`ifdef ACC_WB_SERIALIZER_PERF_CNT_EN
      ,
      .perf_rsp_cnt_o (nd_perf_rsp),
      .perf_dual_cnt_o(nd_perf_dual)
`endif
   );

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Present one response for a single cycle; caller ensures it is accepted
   task automatic send(input logic [AW-1:0] rd, input logic [DW-1:0] lo,
                       input logic [DW-1:0] hi, input logic dual, input logic err);
      x_rsp_valid  = 1'b1;
      x_rsp_rd     = rd;
      x_rsp_data   = {hi, lo};
      x_rsp_dualwb = dual;
      x_rsp_error  = err;
      tick();
      x_rsp_valid  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      x_rsp_valid = 1'b0; nd_valid = 1'b0; x_rsp_rd = '0; x_rsp_data = '0;
      x_rsp_dualwb = 1'b0; x_rsp_error = 1'b0; wb_ready = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      repeat (2) tick();
      #1;
      checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid); end
      checks++; if (x_rsp_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", x_rsp_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if ({wb_addr, wb_data, wb_error} !== '0) begin failures++; $display("FAIL reset_outputs got=%0h/%0h/%0b exp=0", wb_addr, wb_data, wb_error); end
   endtask

   task automatic test_single();
      wb_ready = 1'b1;
      send(5'd5, 32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b0);
      #1;
      checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", wb_valid); end
      checks++; if (wb_addr !== 5'd5) begin failures++; $display("FAIL single_addr got=%0d exp=5", wb_addr); end
      checks++; if (wb_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_data got=%0h exp=deadbeef", wb_data); end
      checks++; if (wb_error !== 1'b0) begin failures++; $display("FAIL single_err got=%0b exp=0", wb_error); end
      tick(); #1;
      checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_empty got=%0b/%0b exp=0/0", wb_valid, busy); end
   endtask

   task automatic test_dual();
      wb_ready = 1'b1;
      send(5'd10, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0);
      #1;
      checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd10 || wb_data !== 32'h1111_1111) begin failures++; $display("FAIL dual_beat1 got=%0b/%0d/%0h exp=1/10/11111111", wb_valid, wb_addr, wb_data); end
      checks++; if (x_rsp_ready !== 1'b0) begin failures++; $display("FAIL dual_ready_beat1 got=%0b exp=0", x_rsp_ready); end
      tick(); #1;
      checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd11 || wb_data !== 32'h2222_2222 || wb_error !== 1'b0) begin failures++; $display("FAIL dual_beat2 got=%0b/%0d/%0h/%0b exp=1/11/22222222/0", wb_valid, wb_addr, wb_data, wb_error); end
      checks++; if (x_rsp_ready !== 1'b1) begin failures++; $display("FAIL dual_ready_beat2 got=%0b exp=1", x_rsp_ready); end
      tick(); #1;
      checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL dual_empty got=%0b exp=0", wb_valid); end
   endtask

   task automatic test_wrap();
      wb_ready = 1'b1;
      send(5'd31, 32'hAAAA_0001, 32'hBBBB_0002, 1'b1, 1'b0);
      #1;
      checks++; if (wb_addr !== 5'd31 || wb_data !== 32'hAAAA_0001 || wb_error !== 1'b0) begin failures++; $display("FAIL wrap_beat1 got=%0d/%0h/%0b exp=31/aaaa0001/0", wb_addr, wb_data, wb_error); end
      tick(); #1;
      checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd0 || wb_data !== 32'hBBBB_0002 || wb_error !== 1'b1) begin failures++; $display("FAIL wrap_beat2 got=%0b/%0d/%0h/%0b exp=1/0/bbbb0002/1", wb_valid, wb_addr, wb_data, wb_error); end
      tick(); #1;
   endtask

   task automatic test_no_dual();
      wb_ready     = 1'b1;
      nd_valid     = 1'b1;
      x_rsp_rd     = 5'd31;
      x_rsp_data   = {32'hBBBB_0002, 32'hAAAA_0001};
      x_rsp_dualwb = 1'b1;
      x_rsp_error  = 1'b0;
      tick();
      nd_valid = 1'b0;
      #1;
      checks++; if (nd_wb_valid !== 1'b1 || nd_wb_addr !== 5'd31 || nd_wb_data !== 32'hAAAA_0001 || nd_wb_error !== 1'b0) begin failures++; $display("FAIL nodual_beat got=%0b/%0d/%0h/%0b exp=1/31/aaaa0001/0", nd_wb_valid, nd_wb_addr, nd_wb_data, nd_wb_error); end
      checks++; if (nd_ready !== 1'b1) begin failures++; $display("FAIL nodual_ready got=%0b exp=1", nd_ready); end
      tick(); #1;
      checks++; if (nd_wb_valid !== 1'b0 || nd_busy !== 1'b0) begin failures++; $display("FAIL nodual_empty got=%0b/%0b exp=0/0", nd_wb_valid, nd_busy); end
   endtask

   task automatic test_stall();
      wb_ready = 1'b0;
      send(5'd7, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b1);
      // A new single response waits while the writeback port is stalled
      x_rsp_valid  = 1'b1;
      x_rsp_rd     = 5'd9;
      x_rsp_data   = {32'h0, 32'h0BAD_F00D};
      x_rsp_dualwb = 1'b0;
      x_rsp_error  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd7 || wb_data !== 32'hA5A5_A5A5 || wb_error !== 1'b1) begin failures++; $display("FAIL stall_hold[%0d] got=%0b/%0d/%0h/%0b exp=1/7/a5a5a5a5/1", i, wb_valid, wb_addr, wb_data, wb_error); end
         checks++; if (x_rsp_ready !== 1'b0) begin failures++; $display("FAIL stall_ready[%0d] got=%0b exp=0", i, x_rsp_ready); end
         tick();
      end
      wb_ready = 1'b1;
      #1;
      checks++; if (x_rsp_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready got=%0b exp=1", x_rsp_ready); end
      tick();
      x_rsp_valid = 1'b0;
      #1;
      checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd9 || wb_data !== 32'h0BAD_F00D || wb_error !== 1'b0) begin failures++; $display("FAIL stall_next_beat got=%0b/%0d/%0h/%0b exp=1/9/badf00d/0", wb_valid, wb_addr, wb_data, wb_error); end
      tick(); #1;
      checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL stall_empty got=%0b exp=0", wb_valid); end
   endtask

   task automatic test_reset_mid();
      wb_ready = 1'b1;
      send(5'd3, 32'h3333_0000, 32'h4444_0000, 1'b1, 1'b0);
      tick(); #1;
      checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd4) begin failures++; $display("FAIL rstmid_second got=%0b/%0d exp=1/4", wb_valid, wb_addr); end
      rst_n = 1'b1;
      #1;
      checks++; if (wb_valid !== 1'b0 || busy !== 1'b0 || x_rsp_ready !== 1'b1) begin failures++; $display("FAIL rstmid_async got=%0b/%0b/%0b exp=0/0/1", wb_valid, busy, x_rsp_ready); end
      tick();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_beat[%0d] got=%0b exp=0", i, wb_valid); end
      end
   endtask

`ifdef ACC_WB_SERIALIZER_PERF_CNT_EN
   task automatic test_perf();
      wb_ready = 1'b1;
      checks++; if (perf_rsp !== 32'd0 || perf_dual !== 32'd0) begin failures++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_rsp, perf_dual); end
      send(5'd1, 32'h1, 32'h0, 1'b0, 1'b0); tick();
      send(5'd2, 32'h2, 32'h3, 1'b1, 1'b0); tick(); tick();
      send(5'd3, 32'h4, 32'h0, 1'b0, 1'b0); tick(); #1;
      checks++; if (perf_rsp !== 32'd3) begin failures++; $display("FAIL perf_rsp got=%0d exp=3", perf_rsp); end
      checks++; if (perf_dual !== 32'd1) begin failures++; $display("FAIL perf_dual got=%0d exp=1", perf_dual); end
   endtask
`endif

   // Random traffic against a queue of beats still owed to the register file
   task automatic test_random();
      beat_t  q[$];
      beat_t  b;
      logic   exp_valid, exp_ready;
      for (int cyc = 0; cyc < 400; cyc++) begin
         x_rsp_valid  = ($urandom_range(0, 1) == 1);
         x_rsp_rd     = AW'($urandom);
         x_rsp_data   = {$urandom, $urandom};
         x_rsp_dualwb = ($urandom_range(0, 1) == 1);
         x_rsp_error  = ($urandom_range(0, 7) == 0);
         wb_ready     = ($urandom_range(0, 3) != 0);
         #1;
         exp_valid = (q.size() != 0);
         // Only one response is held: accept when nothing is owed, or the last
         // owed beat is leaving this cycle
         exp_ready = (q.size() == 0) || ((q.size() == 1) && wb_ready);
         checks++; if (wb_valid !== exp_valid) begin failures++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", cyc, wb_valid, exp_valid); end
         checks++; if (busy !== exp_valid) begin failures++; $display("FAIL rand_busy cyc=%0d got=%0b exp=%0b", cyc, busy, exp_valid); end
         checks++; if (x_rsp_ready !== exp_ready) begin failures++; $display("FAIL rand_ready cyc=%0d got=%0b exp=%0b", cyc, x_rsp_ready, exp_ready); end
         if (exp_valid) begin
            checks++;
            if (wb_addr !== q[0].addr || wb_data !== q[0].data || wb_error !== q[0].err) begin
               failures++;
               $display("FAIL rand_beat cyc=%0d got=%0d/%0h/%0b exp=%0d/%0h/%0b", cyc, wb_addr, wb_data, wb_error, q[0].addr, q[0].data, q[0].err);
            end
         end
         @(posedge clk_i);
         if (exp_valid && wb_ready) void'(q.pop_front());
         if (x_rsp_valid && exp_ready) begin
            b.addr = x_rsp_rd;
            b.data = x_rsp_data[DW-1:0];
            b.err  = x_rsp_error;
            q.push_back(b);
            if (x_rsp_dualwb) begin
               b.addr = x_rsp_rd + AW'(1);
               b.data = x_rsp_data[2*DW-1:DW];
               b.err  = x_rsp_error || (x_rsp_rd == AW'(31));
               q.push_back(b);
            end
         end
         #1;
      end
      x_rsp_valid = 1'b0;
      wb_ready    = 1'b1;
      repeat (3) tick();
      #1;
      checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rand_drain got=%0b exp=0", wb_valid); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_dual();
      test_wrap();
      test_no_dual();
      test_stall();
      test_reset_mid();
`ifdef ACC_WB_SERIALIZER_PERF_CNT_EN
      test_perf();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
